// File: rtl/pipeline_controller.sv
// Pipeline hazard/flush/stall controller with a small memory-access FSM.
// Detects RAW hazards (with or without forwarding), turns taken branches into
// flushes, freezes the whole pipeline while an external memory access is in
// flight, and keeps a saturating count of hazard stall cycles.
module pipeline_controller #(
  parameter int TIMEOUT    = 15,
  parameter bit FORWARD_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        Two_src,
  input  logic [3:0]  EXE_Dest,
  input  logic        EXE_WB_EN,
  input  logic        EXE_MEM_R_EN,
  input  logic [3:0]  MEM_Dest,
  input  logic        MEM_WB_EN,
  input  logic        Branch_taken,
  input  logic        mem_req_r,
  input  logic        mem_req_w,
  input  logic        mem_ready,
  output logic        hazard,
  output logic        flush,
  output logic        stall_all,
  output logic        sram_start,
  output logic        timeout_err,
  output logic [15:0] hazard_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Last wait-counter value allowed in ACCESS before the access is forced to end.
  localparam logic [3:0] LAST_CNT = 4'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic       mem_req;
  logic       timed_out;
  logic       raw_hazard;

  assign mem_req = mem_req_r | mem_req_w;

  // The access gives up only when the last allowed cycle passes without mem_ready;
  // a ready strobe on that same cycle still counts as a normal completion.
  assign timed_out = (state == ACCESS) && (wait_cnt == LAST_CNT) && !mem_ready;

  // Memory FSM state register; reset drops straight back to IDLE, aborting any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE waits for a request, ACCESS waits for ready or timeout,
  // DONE is a single cycle in which new requests are deliberately ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_req) state_next = ACCESS;
      ACCESS:  if (mem_ready || (wait_cnt == LAST_CNT)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Wait counter runs only inside ACCESS and sits at zero otherwise, so every
  // access starts counting from zero on its first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (state == ACCESS) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Start pulse is registered so it lines up with the first ACCESS cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_start <= 1'b0;
    end else begin
      sram_start <= (state == IDLE) && mem_req;
    end
  end

  // Timeout flag is sticky until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (timed_out) begin
      timeout_err <= 1'b1;
    end
  end

  // Freeze everything while a request is about to start or an access is running.
  always_comb begin
    stall_all = ((state == IDLE) && mem_req) || (state == ACCESS);
  end

  // RAW hazard: with forwarding only a load in EXE can't be bypassed;
  // without it any pending writer in EXE or MEM must stall the consumer.
  always_comb begin
    raw_hazard = 1'b0;
    if (FORWARD_EN) begin
      raw_hazard = EXE_MEM_R_EN &&
                   ((src1 == EXE_Dest) || (Two_src && (src2 == EXE_Dest)));
    end else begin
      raw_hazard = ((src1 == EXE_Dest) && EXE_WB_EN) ||
                   ((src1 == MEM_Dest) && MEM_WB_EN) ||
                   (Two_src && (((src2 == EXE_Dest) && EXE_WB_EN) ||
                                ((src2 == MEM_Dest) && MEM_WB_EN)));
    end
  end

  // A global stall masks both flush and hazard; a branch outranks a hazard
  // because the stalled instruction is about to be squashed anyway.
  always_comb begin
    flush  = Branch_taken && !stall_all;
    hazard = raw_hazard && !flush && !stall_all;
  end

  // Saturating hazard-cycle counter for performance monitoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_cycles <= 16'd0;
    end else if (hazard && (hazard_cycles != 16'hFFFF)) begin
      hazard_cycles <= hazard_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: one instance without forwarding
// and one with forwarding share all inputs and are compared every cycle against
// a transaction-level reference model, first with directed scenarios and then
// with random traffic including asynchronous reset pulses.
module tb_pipeline_controller;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2, EXE_Dest, MEM_Dest;
  logic        Two_src, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN;
  logic        Branch_taken, mem_req_r, mem_req_w, mem_ready;

  logic        hazard0, flush0, stall0, start0, terr0;
  logic [15:0] hcnt0;
  logic        hazard1, flush1, stall1, start1, terr1;
  logic [15:0] hcnt1;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: an access is tracked by how many ACCESS cycles it has used.
  bit mBusy, mDone, mStart, mTerr;
  int mAge;
  int mHcnt[2];

  pipeline_controller #(.TIMEOUT(TIMEOUT), .FORWARD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(Two_src),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .Branch_taken(Branch_taken),
    .mem_req_r(mem_req_r), .mem_req_w(mem_req_w), .mem_ready(mem_ready),
    .hazard(hazard0), .flush(flush0), .stall_all(stall0),
    .sram_start(start0), .timeout_err(terr0), .hazard_cycles(hcnt0)
  );

  pipeline_controller #(.TIMEOUT(TIMEOUT), .FORWARD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(Two_src),
    .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
    .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN), .Branch_taken(Branch_taken),
    .mem_req_r(mem_req_r), .mem_req_w(mem_req_w), .mem_ready(mem_ready),
    .hazard(hazard1), .flush(flush1), .stall_all(stall1),
    .sram_start(start1), .timeout_err(terr1), .hazard_cycles(hcnt1)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                               input logic [3:0] ed, input logic ewb, input logic eld,
                               input logic [3:0] md, input logic mwb, input logic br,
                               input logic rq_r, input logic rq_w, input logic rdy);
    src1 = s1; src2 = s2; Two_src = two;
    EXE_Dest = ed; EXE_WB_EN = ewb; EXE_MEM_R_EN = eld;
    MEM_Dest = md; MEM_WB_EN = mwb; Branch_taken = br;
    mem_req_r = rq_r; mem_req_w = rq_w; mem_ready = rdy;
  endtask

  // Hazard rules straight from the register-dependency definitions.
  function automatic bit rawHazard(input bit fwd);
    bit dep1Exe, dep2Exe, dep1Mem, dep2Mem;
    dep1Exe = (src1 == EXE_Dest);
    dep2Exe = Two_src && (src2 == EXE_Dest);
    dep1Mem = (src1 == MEM_Dest);
    dep2Mem = Two_src && (src2 == MEM_Dest);
    if (fwd) return EXE_MEM_R_EN && (dep1Exe || dep2Exe);
    return (EXE_WB_EN && (dep1Exe || dep2Exe)) || (MEM_WB_EN && (dep1Mem || dep2Mem));
  endfunction

  function automatic bit expStall();
    bit req = mem_req_r || mem_req_w;
    return mBusy || (!mBusy && !mDone && req);
  endfunction

  function automatic bit expFlush();
    return Branch_taken && !expStall();
  endfunction

  function automatic bit expHazard(input bit fwd);
    return rawHazard(fwd) && !expFlush() && !expStall();
  endfunction

  task automatic modelReset();
    mBusy = 0; mDone = 0; mStart = 0; mTerr = 0; mAge = 0;
    mHcnt[0] = 0; mHcnt[1] = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelClock();
    bit req = mem_req_r || mem_req_w;
    if (expHazard(1'b0) && mHcnt[0] < 65535) mHcnt[0]++;
    if (expHazard(1'b1) && mHcnt[1] < 65535) mHcnt[1]++;
    if (mDone) begin
      mDone = 0;
      mStart = 0;
    end else if (mBusy) begin
      mAge++;
      mStart = 0;
      if (mem_ready || mAge == TIMEOUT) begin
        mBusy = 0;
        mDone = 1;
        if (!mem_ready) mTerr = 1;
      end
    end else begin
      mStart = req;
      if (req) begin
        mBusy = 1;
        mAge = 0;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".stall0"},  {15'd0, stall0},  {15'd0, expStall()});
    checkOutput({tag, ".stall1"},  {15'd0, stall1},  {15'd0, expStall()});
    checkOutput({tag, ".flush0"},  {15'd0, flush0},  {15'd0, expFlush()});
    checkOutput({tag, ".flush1"},  {15'd0, flush1},  {15'd0, expFlush()});
    checkOutput({tag, ".hazard0"}, {15'd0, hazard0}, {15'd0, expHazard(1'b0)});
    checkOutput({tag, ".hazard1"}, {15'd0, hazard1}, {15'd0, expHazard(1'b1)});
    checkOutput({tag, ".start0"},  {15'd0, start0},  {15'd0, mStart});
    checkOutput({tag, ".start1"},  {15'd0, start1},  {15'd0, mStart});
    checkOutput({tag, ".terr0"},   {15'd0, terr0},   {15'd0, mTerr});
    checkOutput({tag, ".terr1"},   {15'd0, terr1},   {15'd0, mTerr});
    checkOutput({tag, ".hcnt0"},   hcnt0,            16'(mHcnt[0]));
    checkOutput({tag, ".hcnt1"},   hcnt1,            16'(mHcnt[1]));
  endtask

  // Called just after a falling edge with inputs applied: check, then clock.
  task automatic stepCycle(input string tag);
    #1;
    checkAll(tag);
    modelClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    applyStimulus(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    modelReset();
    repeat (2) @(negedge clk);

    // Reset state, and stall_all following a request while reset is held.
    checkAll("reset");
    mem_req_r = 1'b1;
    #1;
    checkAll("reset_req");
    checkOutput("reset_req_stall", {15'd0, stall0}, 16'd1);
    @(negedge clk);
    idleInputs();
    rst = 1'b0;

    // Load-use with forwarding: one hazard cycle on dut1 only if EXE is a load.
    applyStimulus(4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("ld_use_hazard", {15'd0, hazard1}, 16'd1);
    stepCycle("ld_use");
    idleInputs();
    #1;
    checkOutput("ld_use_count", hcnt1, 16'd1);
    applyStimulus(4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("no_load_hazard", {15'd0, hazard1}, 16'd0);
    stepCycle("no_load");

    // Without forwarding, src2 only matters when Two_src is set.
    applyStimulus(4'd0, 4'd5, 1'b0, 4'd9, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("src2_unused", {15'd0, hazard0}, 16'd0);
    stepCycle("src2_unused");
    applyStimulus(4'd0, 4'd5, 1'b1, 4'd9, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("src2_used", {15'd0, hazard0}, 16'd1);
    stepCycle("src2_used");

    // Load with ready on the third ACCESS cycle.
    idleInputs(); mem_req_r = 1'b1;
    stepCycle("ld_req");
    #1; checkOutput("ld_start", {15'd0, start0}, 16'd1);
    stepCycle("ld_acc1");
    stepCycle("ld_acc2");
    mem_ready = 1'b1;
    #1; checkOutput("ld_acc3_stall", {15'd0, stall0}, 16'd1);
    stepCycle("ld_acc3");
    idleInputs();
    #1; checkOutput("ld_done_stall", {15'd0, stall0}, 16'd0);
    stepCycle("ld_done");
    stepCycle("ld_idle");

    // Ready on the very last allowed cycle completes without a timeout.
    mem_req_w = 1'b1;
    stepCycle("edge_req");
    for (int i = 1; i < TIMEOUT; i++) stepCycle("edge_acc");
    mem_ready = 1'b1;
    stepCycle("edge_last");
    idleInputs();
    #1; checkOutput("edge_no_terr", {15'd0, terr0}, 16'd0);
    stepCycle("edge_done");

    // No ready at all: forced completion after TIMEOUT ACCESS cycles, sticky error.
    mem_req_r = 1'b1;
    stepCycle("to_req");
    mem_req_r = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) stepCycle("to_acc");
    #1;
    checkOutput("to_done_stall", {15'd0, stall0}, 16'd0);
    checkOutput("to_terr", {15'd0, terr0}, 16'd1);
    stepCycle("to_done");
    repeat (3) stepCycle("to_hold");
    checkOutput("to_terr_held", {15'd0, terr0}, 16'd1);

    // Branch beats hazard; a branch during ACCESS flushes only in DONE.
    applyStimulus(4'd2, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("br_flush", {15'd0, flush0}, 16'd1);
    checkOutput("br_hazard", {15'd0, hazard0}, 16'd0);
    stepCycle("br_haz");
    idleInputs(); Branch_taken = 1'b1; mem_req_r = 1'b1;
    stepCycle("br_req");
    #1; checkOutput("br_acc_flush", {15'd0, flush0}, 16'd0);
    stepCycle("br_acc1");
    mem_ready = 1'b1;
    stepCycle("br_acc2");
    mem_ready = 1'b0; mem_req_r = 1'b0;
    #1; checkOutput("br_done_flush", {15'd0, flush0}, 16'd1);
    stepCycle("br_done");
    idleInputs();

    // Asynchronous reset in the middle of ACCESS cycle 2, request still pending.
    mem_req_r = 1'b1;
    stepCycle("ar_req");
    stepCycle("ar_acc1");
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("ar_async");
    checkOutput("ar_terr", {15'd0, terr0}, 16'd0);
    @(posedge clk);
    #1;
    checkOutput("ar_no_repulse", {15'd0, start0}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    stepCycle("ar_restart_req");
    #1; checkOutput("ar_restart_start", {15'd0, start0}, 16'd1);
    mem_ready = 1'b1;
    stepCycle("ar_restart_acc");
    idleInputs();
    stepCycle("ar_restart_done");

    // Saturation of the hazard counter, preloaded close to the top.
    force dut0.hazard_cycles = 16'hFFFE;
    #1;
    release dut0.hazard_cycles;
    mHcnt[0] = 65534;
    @(negedge clk);
    applyStimulus(4'd7, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) stepCycle("sat");
    checkOutput("sat_value", hcnt0, 16'hFFFF);
    idleInputs();
    pulseReset();

    // Random traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
                    4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                    4'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 80) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("rand_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        stepCycle("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
